crossy_game_ctrl: RTL and testbench
===================================

Name: crossy_game_ctrl

Overview:
- Game-flow sequencer for the Crossy Road VGA design. Sits between the VGA timing, the button input, the scroll_v/scroll_h obstacle engines and the pixel-level collision compare.
- Owns the game state machine, lives, frame-synchronous button debounce, the reset/freeze controls for the scroll engines, and the high score.
- Replaces direct wiring of the collision compare into the scroll reset with a sequenced hit/respawn flow.

Parameters:
- LIVES_INIT, 3, lives loaded at game start; range 1..3.
- HIT_FRAMES, 60, frames spent in HIT before respawn or game over.
- OVER_FRAMES, 120, minimum frames in OVER before a button press is accepted.
- FLASH_DIV, 8, frames per flash half-period during HIT.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- vsync  in  1  VGA vsync, active-low; its falling edge defines frame_tick
- move_btn  in  1  raw asynchronous button
- collision  in  1  pixel-level obstacle-and-chicken overlap, combinational, valid any cycle
- score  in  8  current score from scroll_v
- move_pulse  out  1  debounced one-cycle move request to scroll_v
- game_rst  out  1  one-cycle reset pulse to scroll_v/scroll_h
- freeze  out  1  holds scroll engines (no obstacle motion)
- flash  out  1  display invert request during HIT
- state  out  2  0=IDLE, 1=PLAY, 2=HIT, 3=OVER
- lives  out  2  remaining lives
- high_score  out  8  best score since reset

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE, lives=LIVES_INIT, high_score=0, move_pulse=0, game_rst=0, freeze=1, flash=0, frame counter=0, button history=0.
- Button path:
  - move_btn passes through a 2-flop synchronizer.
  - The synchronized level is sampled only on frame_tick (this is the debounce).
  - A press event occurs when the previous frame sample is 0 and the current sample is 1.
- frame_tick: one cycle, on the cycle after the synchronized vsync goes 1->0.
- Collision latch: collision is OR-ed into a sticky hit_flag in any cycle while in PLAY. hit_flag is cleared on every frame_tick, after it has been evaluated.
- IDLE:
  - freeze=1.
  - On a press: game_rst=1 for one cycle, lives=LIVES_INIT, go to PLAY.
  - That press does not produce move_pulse.
- PLAY:
  - freeze=0.
  - Each press produces move_pulse=1 on the frame_tick cycle.
  - On frame_tick with hit_flag=1: go to HIT, lives decrements by 1 (saturating at 0), frame counter cleared.
  - If hit and press occur on the same tick, the hit wins and no move_pulse is issued.
- HIT:
  - freeze=1.
  - flash toggles every FLASH_DIV frames, starting at 1 on entry.
  - Presses are ignored.
  - After HIT_FRAMES ticks: if lives≠0, game_rst pulses for one cycle and the block returns to PLAY with flash=0.
  - If lives=0, go to OVER.
- OVER:
  - freeze=1, flash=0.
  - Presses are ignored until OVER_FRAMES ticks have elapsed.
  - The next press after that goes to IDLE (no game_rst).
- Frame counter: 8 bits, saturating at 255, cleared on every state entry.
- game_rst and move_pulse are registered, never asserted together, and are never asserted in the same cycle as freeze rises.
- Mid-game reset via rst_n: all outputs return to reset values immediately.

Optional Feature:
- CROSSY_HISCORE_EN defined:
  - On entry to HIT, if score > high_score, high_score ← score (unsigned 8-bit compare).
  - high_score survives game_rst and is cleared only by rst_n.
- Not defined: high_score is tied to 8'h00 and no compare or register logic is synthesized.

Test Plan:
- Start: after reset, hold move_btn=1 across 2 frame ticks -> exactly one game_rst pulse, state=1, lives=3, move_pulse stays 0, freeze falls to 0.
- Move: in PLAY, press for one frame, release for one frame, repeat 3 times -> exactly 3 move_pulse cycles, each coincident with frame_tick.
- Bounce: toggle move_btn every 100 clk within one frame -> at most one move_pulse.
- Hit: in PLAY, raise collision for 1 clk mid-frame -> at the next frame_tick state=2, lives=2, freeze=1, flash=1. flash toggles after 8 frames. After 60 frames game_rst pulses once and state=1.
- Hit with simultaneous press: collision and a press land on the same tick -> state=2, no move_pulse.
- Game over: three hits -> lives=0, state=3. A press at frame 50 is ignored. A press after frame 120 gives state=0.
- With CROSSY_HISCORE_EN: score=8'd42 at the first hit, then 8'd17 at the second -> high_score=42. After rst_n low, high_score=0.

Source files
------------

// File: rtl/crossy_game_ctrl.sv
// crossy_game_ctrl: game-flow sequencer (state, lives, frame debounce, scroll reset/freeze); CROSSY_HISCORE_EN adds high score tracking
module crossy_game_ctrl #(
    parameter int LIVES_INIT  = 3,
    parameter int HIT_FRAMES  = 60,
    parameter int OVER_FRAMES = 120,
    parameter int FLASH_DIV   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync_i,
    input  logic       move_btn_i,
    input  logic       collision_i,
    input  logic [7:0] score_i,
    output logic       move_pulse_o,
    output logic       game_rst_o,
    output logic       freeze_o,
    output logic       flash_o,
    output logic [1:0] state_o,
    output logic [1:0] lives_o,
    output logic [7:0] high_score_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;
    localparam logic [1:0] LIVES0     = 2'(LIVES_INIT);
    localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0] OVER_MIN   = 8'(OVER_FRAMES);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);
    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d, rst_sync_q;
    logic [7:0] cnt_q, cnt_d, fdiv_q, fdiv_d;
    logic       flash_q, flash_d, hit_q, hit_d, move_q, move_d, grst_q, grst_d;
    logic       btn_s1_q, btn_s2_q, btn_hist_q, vs_s1_q, vs_s2_q, vs_prev_q;
    logic       rst_sn, fall, press, hit_now;
    // Decisions are taken in the cycle the synchronized vsync falls, so registered outputs land on the frame tick cycle
    assign rst_sn  = rst_sync_q[1];
    assign fall    = vs_prev_q & ~vs_s2_q;
    assign press   = fall & btn_s2_q & ~btn_hist_q;
    assign hit_now = hit_q | collision_i;
    // Reset asserts immediately and releases two clocks later, aligned to clk
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    // Synchronizers, frame-sampled button history and all game state
    always_ff @(posedge clk or negedge rst_sn) begin
        if (!rst_sn) begin
            state_q    <= IDLE;
            lives_q    <= LIVES0;
            cnt_q      <= 8'h00;
            fdiv_q     <= 8'h00;
            flash_q    <= 1'b0;
            hit_q      <= 1'b0;
            move_q     <= 1'b0;
            grst_q     <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_hist_q <= 1'b0;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            cnt_q      <= cnt_d;
            fdiv_q     <= fdiv_d;
            flash_q    <= flash_d;
            hit_q      <= hit_d;
            move_q     <= move_d;
            grst_q     <= grst_d;
            btn_s1_q   <= move_btn_i;
            btn_s2_q   <= btn_s1_q;
            btn_hist_q <= fall ? btn_s2_q : btn_hist_q;
            vs_s1_q    <= vsync_i;
            vs_s2_q    <= vs_s1_q;
            vs_prev_q  <= vs_s2_q;
        end
    end
    // Next state: press starts a game, a latched hit ends the frame, timers drive respawn and game over
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = fall ? ((cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1) : cnt_q;
        fdiv_d  = fdiv_q;
        flash_d = flash_q;
        move_d  = 1'b0;
        grst_d  = 1'b0;
        hit_d   = (state_q == PLAY) && !fall && hit_now;
        case (state_q)
            IDLE: if (press) begin
                state_d = PLAY;
                grst_d  = 1'b1;
                lives_d = LIVES0;
                cnt_d   = 8'h00;
            end
            PLAY: if (fall && hit_now) begin
                state_d = HIT;
                lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                cnt_d   = 8'h00;
                fdiv_d  = 8'h00;
                flash_d = 1'b1;
            end else move_d = press;
            HIT: if (fall) begin
                if (cnt_q >= HIT_LAST) begin
                    state_d = (lives_q != 2'd0) ? PLAY : OVER;
                    grst_d  = lives_q != 2'd0;
                    flash_d = 1'b0;
                    cnt_d   = 8'h00;
                end else begin
                    fdiv_d  = (fdiv_q == FLASH_LAST) ? 8'h00 : fdiv_q + 8'd1;
                    flash_d = (fdiv_q == FLASH_LAST) ? ~flash_q : flash_q;
                end
            end
            OVER: if (press && cnt_q >= OVER_MIN) begin
                state_d = IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end
    assign move_pulse_o = move_q;
    assign game_rst_o   = grst_q;
    assign freeze_o     = state_q != PLAY;
    assign flash_o      = flash_q;
    assign state_o      = state_q;
    assign lives_o      = lives_q;
`ifdef CROSSY_HISCORE_EN
    logic [7:0] hs_q;
    // Capture a new best score at the moment a hit is registered
    always_ff @(posedge clk or negedge rst_sn)
        if (!rst_sn) hs_q <= 8'h00;
        else if (state_q == PLAY && state_d == HIT && score_i > hs_q) hs_q <= score_i;
    assign high_score_o = hs_q;
`else
    logic unused_score;
    assign unused_score = ^score_i;
    assign high_score_o = 8'h00;
`endif
endmodule

// File: tb/tb_crossy_game_ctrl.sv
// tb_crossy_game_ctrl: table-driven and sequence checks of the game-flow sequencer
module tb_crossy_game_ctrl;
`ifdef CROSSY_HISCORE_EN
    localparam logic [7:0] HS_EXP = 8'd42;
`else
    localparam logic [7:0] HS_EXP = 8'd0;
`endif
    localparam int SHORT = 40;
    logic       clk, rst_n, vsync, move_btn, collision;
    logic [7:0] score;
    logic       move_pulse_o, game_rst_o, freeze_o, flash_o;
    logic [1:0] state_o, lives_o;
    logic [7:0] high_score_o;
    logic [3:0] vs_hist = 4'hf;
    logic       ref_tick, frz_prev = 1'b1;
    int         n_move = 0, n_grst = 0, n_bad = 0, n_err = 0, n_chk = 0, m0;

    typedef struct {
        logic       btn;
        logic       coll;
        logic [1:0] st;
        logic [1:0] lv;
        logic       frz;
        logic       fl;
        int         mv;
        int         gr;
    } vec_t;
    vec_t tbl [10];

    crossy_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .move_btn_i(move_btn),
        .collision_i(collision), .score_i(score), .move_pulse_o(move_pulse_o),
        .game_rst_o(game_rst_o), .freeze_o(freeze_o), .flash_o(flash_o),
        .state_o(state_o), .lives_o(lives_o), .high_score_o(high_score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame tick: the cycle after the two-flop-synchronized vsync falls
    always @(posedge clk) vs_hist <= {vs_hist[2:0], vsync};
    assign ref_tick = vs_hist[3] & ~vs_hist[2];

    // Pulse counters and protocol rules, sampled mid-cycle
    always @(negedge clk) begin
        if (move_pulse_o) n_move++;
        if (game_rst_o) n_grst++;
        if (move_pulse_o && !ref_tick) n_bad++;
        if (move_pulse_o && game_rst_o) n_bad++;
        if (freeze_o && !frz_prev && (move_pulse_o || game_rst_o)) n_bad++;
        frz_prev = freeze_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic step(input logic btn, input logic coll);
        move_btn = btn;
        repeat (SHORT / 2) @(negedge clk);
        collision = coll;
        @(negedge clk);
        collision = 1'b0;
        repeat (SHORT / 2) @(negedge clk);
        vs_pulse();
    endtask

    task automatic hit_frames(input int n);
        for (int k = 1; k <= n; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 0, 1};
        tbl[1] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 0, 1};
        tbl[2] = '{1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 0, 1};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1, 1};
        tbl[4] = '{1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 1, 1};
        tbl[5] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 2, 1};
        tbl[6] = '{1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 2, 1};
        tbl[7] = '{1'b1, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 3, 1};
        tbl[8] = '{1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0, 3, 1};
        tbl[9] = '{1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 3, 1};
        rst_n = 1'b0; vsync = 1'b1; move_btn = 1'b0; collision = 1'b0; score = 8'd42;
        repeat (3) @(negedge clk);
        chk("reset state", state_o, 0);
        chk("reset lives", lives_o, 3);
        chk("reset freeze", freeze_o, 1);
        chk("reset flash", flash_o, 0);
        chk("reset move_pulse", move_pulse_o, 0);
        chk("reset game_rst", game_rst_o, 0);
        chk("reset high_score", high_score_o, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].btn, tbl[i].coll);
            chk($sformatf("row%0d state", i), state_o, tbl[i].st);
            chk($sformatf("row%0d lives", i), lives_o, tbl[i].lv);
            chk($sformatf("row%0d freeze", i), freeze_o, tbl[i].frz);
            chk($sformatf("row%0d flash", i), flash_o, tbl[i].fl);
            chk($sformatf("row%0d moves", i), n_move, tbl[i].mv);
            chk($sformatf("row%0d game_rst", i), n_grst, tbl[i].gr);
        end
        for (int k = 1; k <= 60; k++) begin
            step(1'b0, 1'b0);
            if (k == 7) chk("hit flash f7", flash_o, 1);
            if (k == 8) chk("hit flash f8", flash_o, 0);
            if (k == 16) chk("hit flash f16", flash_o, 1);
            if (k == 59) chk("hit state f59", state_o, 2);
        end
        chk("respawn state", state_o, 1);
        chk("respawn game_rst", n_grst, 2);
        chk("respawn flash", flash_o, 0);
        chk("respawn freeze", freeze_o, 0);
        chk("respawn lives", lives_o, 2);
        m0 = n_move;
        for (int i = 0; i < 9; i++) begin
            move_btn = ~move_btn;
            repeat (100) @(negedge clk);
        end
        vs_pulse();
        step(1'b0, 1'b0);
        chk("bounce moves", n_move - m0, 1);
        score = 8'd17;
        step(1'b0, 1'b1);
        chk("hit2 state", state_o, 2);
        chk("hit2 lives", lives_o, 1);
        hit_frames(60);
        chk("hit2 respawn state", state_o, 1);
        chk("hit2 respawn game_rst", n_grst, 3);
        step(1'b0, 1'b1);
        chk("hit3 state", state_o, 2);
        chk("hit3 lives", lives_o, 0);
        hit_frames(60);
        chk("over state", state_o, 3);
        chk("over flash", flash_o, 0);
        chk("over freeze", freeze_o, 1);
        chk("over no game_rst", n_grst, 3);
        chk("high_score", high_score_o, HS_EXP);
        for (int k = 1; k <= 125; k++) begin
            step(k == 50 || k == 125, 1'b0);
            if (k == 50) chk("over early press", state_o, 3);
            if (k == 124) chk("over before press", state_o, 3);
        end
        chk("over late press", state_o, 0);
        chk("idle freeze", freeze_o, 1);
        chk("idle no game_rst", n_grst, 3);
        chk("total moves", n_move, 4);
        chk("pulse protocol", n_bad, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("restart state", state_o, 1);
        chk("restart lives", lives_o, 3);
        chk("restart game_rst", n_grst, 4);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset state", state_o, 0);
        chk("midreset lives", lives_o, 3);
        chk("midreset freeze", freeze_o, 1);
        chk("midreset flash", flash_o, 0);
        chk("midreset move_pulse", move_pulse_o, 0);
        chk("midreset game_rst", game_rst_o, 0);
        chk("midreset high_score", high_score_o, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
